// File: rtl/m_lat_rf.sv
`default_nettype none
// ============================================================================
// Module   : m_lat_rf
// Purpose  : Latch-based register file: flop write staging, per-word gated
//            latch words, registered read port, post-reset zero sweep.
//            Optional macro M_LAT_RF_BYPASS_EN forwards same-edge write data.
// Revision : 1.0 - initial release
// ============================================================================
module m_lat_rf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ready,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ic_q, ic_d;
    logic             wv_q, wv_d;
    logic [AW-1:0]    wa_q, wa_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic             ready_q, ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic [WIDTH-1:0] w_rd_words [DEPTH];
    logic             w_wr_in_range;
    logic             w_rd_in_range;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_last_ic;

    assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);
    assign w_wr_ok       = wr_en & ready_q & w_wr_in_range;
    assign w_rd_ok       = rd_en & ready_q;
    assign w_last_ic     = ({1'b0, ic_q} == (c_depth - 1'b1));

    // Storage words. The enable is captured while clk is high so the low-phase
    // gate can only open cleanly; rst_n closes every gate immediately.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic             en_l;
        logic             gate;
        logic [WIDTH-1:0] word_l;

        always_latch begin
            if (clk) en_l <= wv_q && (wa_q == AW'(i));
        end

        assign gate = en_l & ~clk & rst_n;

        always_latch begin
            if (gate) word_l <= wd_q;
        end

        assign w_rd_words[i] = word_l;
    end

    always_comb begin
        state_d    = state_q;
        ic_d       = ic_q;
        wv_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        ready_d    = (state_q == ST_DONE);
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        case (state_q)
            ST_INIT: begin
                // Zero-sweep reuses the write staging path, one word per cycle.
                wv_d = 1'b1;
                wa_d = ic_q;
                wd_d = '0;
                if (w_last_ic) state_d = ST_DONE;
                else           ic_d    = ic_q + 1'b1;
            end
            ST_DONE: begin
                if (w_wr_ok) begin
                    wv_d = 1'b1;
                    wa_d = wr_addr;
                    wd_d = wr_data;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (w_rd_ok) begin
            rd_valid_d = 1'b1;
            rd_data_d  = w_rd_in_range ? w_rd_words[rd_addr] : '0;
`ifdef M_LAT_RF_BYPASS_EN
            if (w_wr_ok && w_rd_in_range && (wr_addr == rd_addr)) rd_data_d = wr_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            ic_q       <= '0;
            wv_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ic_q       <= ic_d;
            wv_q       <= wv_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign ready    = ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_m_lat_rf.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_lat_rf
// Purpose  : Directed and randomised self-checking bench for m_lat_rf
//            (DEPTH=16 main instance, DEPTH=12 instance for range checks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_lat_rf;

`ifdef M_LAT_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ready, rd_valid;
    logic        wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;

    logic        ready12, rd_valid12;
    logic        wr_en12, rd_en12;
    logic [3:0]  wr_addr12, rd_addr12;
    logic [31:0] wr_data12, rd_data12;

    int n_pass  = 0;
    int n_total = 0;

    m_lat_rf #(.WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    m_lat_rf #(.WIDTH(32), .DEPTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .ready(ready12),
        .wr_en(wr_en12), .wr_addr(wr_addr12), .wr_data(wr_data12),
        .rd_en(rd_en12), .rd_addr(rd_addr12), .rd_data(rd_data12), .rd_valid(rd_valid12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 64 && ready !== 1'b1; k++) tick();
        n_total++;
        if (ready !== 1'b1) $display("FAIL wait_ready: ready=%b required 1 within 64 edges", ready);
        else n_pass++;
    endtask

    task automatic read16(input logic [3:0] a, input logic [31:0] exp, input string nm);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        n_total++;
        if (rd_valid !== 1'b1 || rd_data !== exp)
            $display("FAIL %s addr %0d: valid=%b data=%h required valid=1 data=%h", nm, a, rd_valid, rd_data, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 0; rd_en = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
        wr_en12 = 0; rd_en12 = 0; wr_addr12 = 0; rd_addr12 = 0; wr_data12 = 0;
        #12;
        n_total++;
        if (ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0)
            $display("FAIL reset_values: ready=%b valid=%b data=%h required 0 0 0", ready, rd_valid, rd_data);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            tick();
            n_total++;
            if (ready !== (e == 17))
                $display("FAIL ready_edge_%0d: ready=%b required %b", e, ready, (e == 17));
            else n_pass++;
        end
        for (int a = 0; a < 16; a++) read16(4'(a), 32'h0, "sweep_zero");
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 0;
        read16(4'd3, 32'hDEADBEEF, "write_read");
        tick();
        n_total++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hDEADBEEF)
            $display("FAIL read_hold: valid=%b data=%h required valid=0 data=deadbeef", rd_valid, rd_data);
        else n_pass++;
    endtask

    task automatic test_same_edge();
        logic [31:0] exp;
        exp = BYPASS ? 32'h12345678 : 32'hA5A5A5A5;
        wr_en = 1; wr_addr = 4'd5; wr_data = 32'hA5A5A5A5;
        tick();
        wr_data = 32'h12345678;
        rd_en = 1; rd_addr = 4'd5;
        tick();
        wr_en = 0; rd_en = 0;
        n_total++;
        if (rd_valid !== 1'b1 || rd_data !== exp)
            $display("FAIL same_edge: valid=%b data=%h required valid=1 data=%h", rd_valid, rd_data, exp);
        else n_pass++;
        read16(4'd5, 32'h12345678, "after_same_edge");
    endtask

    task automatic test_back_to_back();
        wr_en = 1; wr_addr = 4'd2; wr_data = 32'h11111111;
        tick();
        wr_data = 32'h22222222;
        tick();
        wr_addr = 4'd9; wr_data = 32'h99999999;
        tick();
        wr_en = 0;
        read16(4'd2, 32'h22222222, "b2b_last_wins");
        read16(4'd9, 32'h99999999, "b2b_other_addr");
        read16(4'd3, 32'hDEADBEEF, "b2b_untouched");
    endtask

    task automatic test_out_of_range();
        n_total++;
        if (ready12 !== 1'b1) $display("FAIL ready12: ready=%b required 1", ready12);
        else n_pass++;
        wr_en12 = 1; wr_addr12 = 4'd13; wr_data12 = 32'hFFFFFFFF;
        tick();
        wr_addr12 = 4'd11; wr_data12 = 32'h0000000B;
        tick();
        wr_en12 = 0;
        for (int a = 0; a < 14; a++) begin
            logic [31:0] exp;
            exp = (a == 11) ? 32'h0000000B : 32'h0;
            rd_en12 = 1; rd_addr12 = 4'(a);
            tick();
            n_total++;
            if (rd_valid12 !== 1'b1 || rd_data12 !== exp)
                $display("FAIL depth12 addr %0d: valid=%b data=%h required valid=1 data=%h", a, rd_valid12, rd_data12, exp);
            else n_pass++;
        end
        rd_en12 = 0;
    endtask

    task automatic test_reset_mid_write();
        wr_en = 1; wr_addr = 4'd7; wr_data = 32'h77777777;
        rd_en = 1; rd_addr = 4'd3;
        tick();
        wr_en = 0; rd_en = 0;
        n_total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF)
            $display("FAIL pre_reset_read: valid=%b data=%h required valid=1 data=deadbeef", rd_valid, rd_data);
        else n_pass++;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0)
            $display("FAIL async_reset: ready=%b valid=%b data=%h required 0 0 0", ready, rd_valid, rd_data);
        else n_pass++;
        #10;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready();
        read16(4'd7, 32'h0, "resweep_addr7");
        read16(4'd3, 32'h0, "resweep_addr3");
    endtask

    task automatic test_random();
        logic [31:0] model [16];
        logic [31:0] exp_data;
        logic        exp_valid;
        int          bad = 0;
        rst_n = 1'b0;
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        exp_data = rd_data;
        for (int c = 0; c < 10000; c++) begin
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            rd_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            exp_valid = rd_en;
            if (rd_en) exp_data = (BYPASS && wr_en && wr_addr == rd_addr) ? wr_data : model[rd_addr];
            if (wr_en) model[wr_addr] = wr_data;
            tick();
            n_total++;
            if (rd_valid !== exp_valid || rd_data !== exp_data) begin
                if (bad < 10)
                    $display("FAIL random cycle %0d: valid=%b data=%h required valid=%b data=%h", c, rd_valid, rd_data, exp_valid, exp_data);
                bad++;
            end else n_pass++;
        end
        wr_en = 0; rd_en = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_edge();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
